// File: rtl/wr_mem_mc.sv
`default_nettype none
// ============================================================================
// Module   : wr_mem_mc
// Brief    : Multi-channel DRAM write engine. Drains per-input line FIFOs
//            into one MIG user write port, one fixed-length burst at a time,
//            granting requesting channels round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module wr_mem_mc #(
  parameter int NUM_CH      = 2,
  parameter int CH_BITS     = 1,
  parameter int BRST_LEN    = 64,
  parameter int PWIDTH      = 16,
  parameter int DISP_HSTART = 0
) (
  input  logic                  cmd_clk,
  input  logic                  mem_rst,
  input  logic                  calib_done,
  // MIG command port
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [29:0]           cmd_byte_addr,
  input  logic                  cmd_full,
  // MIG write port
  output logic                  wr_en,
  output logic [127:0]          wr_data,
  output logic [15:0]           wr_mask,
  input  logic                  wr_full,
  input  logic                  wr_empty,
  // DRAM port arbiter
  input  logic                  arb_grant,
  // Channel FIFOs
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [NUM_CH-1:0]     ch_ready,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic [NUM_CH*128-1:0] ch_data,
  input  logic [NUM_CH*11-1:0]  ch_line,
  input  logic [NUM_CH-1:0]     ch_half,
  input  logic [NUM_CH-1:0]     ch_bank,
  output logic [NUM_CH-1:0]     ch_rd_en,
  // Status
  output logic [NUM_CH-1:0]     done,
  output logic [NUM_CH-1:0]     err_uf,
  output logic                  busy
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BRST_LEN - 1);
  // Column byte offset of the first displayed pixel; 13-bit wrap is intended.
  localparam logic [12:0] HB_COL = 13'(DISP_HSTART * (PWIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_WRD  = 2'd2,
    S_CMD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [10:0]        line_q, line_d;
  logic               half_q, half_d;
  logic               bank_q, bank_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_en_q, cmd_en_d;
  logic [29:0]        addr_q, addr_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  err_q, err_d;

  logic [NUM_CH-1:0]  req;
  logic               gnt_found;
  logic [SEL_W-1:0]   gnt_idx;
  logic               valid_sel;
  logic               xfer;
  logic [12:0]        col;
  logic [29:0]        addr_next;

  assign cmd_instr     = 3'd2;
  assign cmd_bl        = 6'(BRST_LEN - 1);
  assign wr_mask       = 16'd0;
  assign cmd_en        = cmd_en_q;
  assign cmd_byte_addr = addr_q;
  assign done          = done_q;
  assign err_uf        = err_q;
  assign busy          = (state_q != S_IDLE);

  assign req       = ch_en & ch_ready;
  assign valid_sel = ch_valid[sel_q];
  assign xfer      = (state_q == S_WRD) && valid_sel && !wr_full;
  assign wr_en     = xfer;
  assign wr_data   = ch_data[sel_q*128 +: 128];

  // Byte address: {pad, bank, channel, line[10:0], col[12:0]}
  assign col       = half_q ? (HB_COL + 13'd1024) : HB_COL;
  assign addr_next = (30'(bank_q) << (24 + CH_BITS)) | (30'(sel_q) << 24)
                   | (30'(line_q) << 13) | 30'(col);

  // Pop strobe goes only to the channel currently being drained
  always_comb begin
    ch_rd_en        = '0;
    ch_rd_en[sel_q] = xfer;
  end

  // Round-robin search: first requester strictly after the last grant
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!gnt_found && req[(int'(last_q) + k) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL_W'((int'(last_q) + k) % NUM_CH);
      end
    end
  end

  // Next-state logic for the burst FSM and its registered outputs
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    line_d   = line_q;
    half_d   = half_q;
    bank_d   = bank_q;
    cnt_d    = cnt_q;
    cmd_en_d = 1'b0;
    addr_d   = addr_q;
    done_d   = '0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (calib_done && wr_empty) state_d = S_ARB;
      end
      S_ARB: begin
        if (gnt_found) begin
          sel_d   = gnt_idx;
          last_d  = gnt_idx;
          line_d  = ch_line[gnt_idx*11 +: 11];
          half_d  = ch_half[gnt_idx];
          bank_d  = ch_bank[gnt_idx];
          cnt_d   = '0;
          state_d = S_WRD;
        end
      end
      S_WRD: begin
        // An empty FIFO head stalls the burst and is flagged, never skipped
        if (!valid_sel) err_d[sel_q] = 1'b1;
        if (xfer) begin
          if (cnt_q == LAST_BEAT) state_d = S_CMD;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_CMD: begin
        if (!cmd_full && arb_grant) begin
          cmd_en_d      = 1'b1;
          addr_d        = addr_next;
          done_d[sel_q] = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; last starts at NUM_CH-1 so channel 0 wins first
  always_ff @(posedge cmd_clk) begin
    if (mem_rst) begin
      state_q  <= S_IDLE;
      last_q   <= SEL_W'(NUM_CH - 1);
      sel_q    <= '0;
      line_q   <= '0;
      half_q   <= 1'b0;
      bank_q   <= 1'b0;
      cnt_q    <= '0;
      cmd_en_q <= 1'b0;
      addr_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      line_q   <= line_d;
      half_q   <= half_d;
      bank_q   <= bank_d;
      cnt_q    <= cnt_d;
      cmd_en_q <= cmd_en_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wr_mem_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_mem_mc
// Brief    : Scoreboard bench for wr_mem_mc (2 channels, 64-word bursts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_mem_mc;

  localparam int NCH = 2;
  localparam int BL  = 64;

  // Hand-computed addresses: bank at bit 25, channel at bit 24,
  // line at [23:13], column at [12:0] (second half => column 1024).
  localparam logic [29:0] A_T1 = 30'h0000A400; // bank0 ch0 line5 col1024
  localparam logic [29:0] A_C0 = 30'h0200E000; // bank1 ch0 line7 col0
  localparam logic [29:0] A_C1 = 30'h01012400; // bank0 ch1 line9 col1024

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 mem_rst, calib_done;
  logic                 cmd_en;
  logic [2:0]           cmd_instr;
  logic [5:0]           cmd_bl;
  logic [29:0]          cmd_byte_addr;
  logic                 cmd_full;
  logic                 wr_en;
  logic [127:0]         wr_data;
  logic [15:0]          wr_mask;
  logic                 wr_full, wr_empty, arb_grant;
  logic [NCH-1:0]       ch_en, ch_ready, ch_valid, ch_half, ch_bank;
  logic [NCH*128-1:0]   ch_data;
  logic [NCH*11-1:0]    ch_line;
  logic [NCH-1:0]       ch_rd_en, done, err_uf;
  logic                 busy;

  wr_mem_mc #(.NUM_CH(NCH), .CH_BITS(1), .BRST_LEN(BL), .PWIDTH(16), .DISP_HSTART(0)) dut (
    .cmd_clk(clk), .mem_rst(mem_rst), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_full(wr_full), .wr_empty(wr_empty), .arb_grant(arb_grant),
    .ch_en(ch_en), .ch_ready(ch_ready), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_line(ch_line), .ch_half(ch_half),
    .ch_bank(ch_bank), .ch_rd_en(ch_rd_en), .done(done),
    .err_uf(err_uf), .busy(busy)
  );

  // Channel FIFO model: head word = {channel, tag, running index}
  logic [63:0] fifo_cnt [NCH] = '{default: 64'd0};
  logic [63:0] exp_next [NCH] = '{default: 64'd0};

  always_comb begin
    for (int c = 0; c < NCH; c++)
      ch_data[c*128 +: 128] = {32'(c), 32'hA5A5_5A5A, fifo_cnt[c]};
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (ch_rd_en[c]) fifo_cnt[c] <= fifo_cnt[c] + 64'd1;
  end

  typedef struct { logic [127:0] d; int ch; } wexp_t;
  typedef struct { logic [29:0] a; logic [NCH-1:0] dn; } cexp_t;
  wexp_t wq[$];
  cexp_t cq[$];
  wexp_t we;
  cexp_t ce;

  int n_chk = 0, n_pass = 0;
  int words_seen = 0, cmds_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops expectations whenever the DUT writes a word or a command
  always @(negedge clk) begin
    if (wr_full) chk("wr_en_while_full", {127'd0, wr_en}, 128'd0);
    if (wr_en) begin
      words_seen++;
      if (wq.size() == 0) chk("unexpected_wr_en", {127'd0, wr_en}, 128'd0);
      else begin
        we = wq.pop_front();
        chk("wr_data", wr_data, we.d);
        chk("ch_rd_en", 128'(ch_rd_en), 128'(2'b01 << we.ch));
        chk("wr_mask", 128'(wr_mask), 128'd0);
      end
    end
    if (cmd_en) begin
      cmds_seen++;
      if (cq.size() == 0) chk("unexpected_cmd_en", {127'd0, cmd_en}, 128'd0);
      else begin
        ce = cq.pop_front();
        chk("cmd_byte_addr", 128'(cmd_byte_addr), 128'(ce.a));
        chk("done", 128'(done), 128'(ce.dn));
        chk("cmd_instr", 128'(cmd_instr), 128'd2);
        chk("cmd_bl", 128'(cmd_bl), 128'd63);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int c, input int nw, input logic with_cmd, input logic [29:0] a);
    for (int i = 0; i < nw; i++) begin
      wq.push_back('{d: {32'(c), 32'hA5A5_5A5A, exp_next[c]}, ch: c});
      exp_next[c] = exp_next[c] + 64'd1;
    end
    if (with_cmd) cq.push_back('{a: a, dn: NCH'(1 << c)});
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (words_seen < n && t < 3000) begin tick(); t++; end
    chk("wait_words_reached", {127'd0, words_seen >= n}, 128'd1);
  endtask

  task automatic wait_cmds(input int n);
    int t = 0;
    while (cmds_seen < n && t < 3000) begin tick(); t++; end
    chk("wait_cmds_reached", {127'd0, cmds_seen >= n}, 128'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_en", {127'd0, cmd_en}, 128'd0);
    chk("rst_cmd_byte_addr", 128'(cmd_byte_addr), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err_uf", 128'(err_uf), 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_wr_en", {127'd0, wr_en}, 128'd0);
    chk("rst_ch_rd_en", 128'(ch_rd_en), 128'd0);
  endtask

  int cmd_hi;

  initial begin
    mem_rst = 1'b1; calib_done = 1'b1; cmd_full = 1'b0; wr_full = 1'b0;
    wr_empty = 1'b1; arb_grant = 1'b1;
    ch_en = 2'b11; ch_ready = 2'b00; ch_valid = 2'b11;
    ch_line = {11'd9, 11'd5}; ch_half = 2'b01; ch_bank = 2'b00;
    tick(); tick();
    @(negedge clk);
    chk_reset_vals();
    tick();
    mem_rst = 1'b0;

    // Single channel ready: ch0, line 5, second half
    push_burst(0, BL, 1'b1, A_T1);
    ch_ready = 2'b01;
    wait_words(1);
    ch_ready = 2'b00;
    wait_cmds(1);
    chk("t1_err_uf", 128'(err_uf), 128'd0);

    // Both ready after reset: ch0, ch1, ch0, ch1
    mem_rst = 1'b1; tick(); tick(); mem_rst = 1'b0;
    ch_line = {11'd9, 11'd7}; ch_half = 2'b10; ch_bank = 2'b01;
    push_burst(0, BL, 1'b1, A_C0);
    push_burst(1, BL, 1'b1, A_C1);
    push_burst(0, BL, 1'b1, A_C0);
    push_burst(1, BL, 1'b1, A_C1);
    ch_ready = 2'b11;
    wait_words(BL + 3*BL + 1);
    ch_ready = 2'b00;
    wait_cmds(5);

    // Write FIFO full for ten cycles mid-burst (ch0 is next in rotation)
    push_burst(0, BL, 1'b1, A_C0);
    ch_ready = 2'b01;
    wait_words(5*BL + 1);
    ch_ready = 2'b00;
    wait_words(5*BL + 10);
    wr_full = 1'b1;
    repeat (10) tick();
    wr_full = 1'b0;
    wait_cmds(6);

    // ch1 head invalid for three cycles mid-burst
    push_burst(1, BL, 1'b1, A_C1);
    ch_ready = 2'b10;
    wait_words(6*BL + 1);
    ch_ready = 2'b00;
    wait_words(6*BL + 20);
    ch_valid = 2'b01;
    repeat (3) tick();
    chk("uf_during_stall", 128'(err_uf), 128'(2'b10));
    ch_valid = 2'b11;
    wait_cmds(7);
    chk("uf_after_burst", 128'(err_uf), 128'(2'b10));
    repeat (5) tick();
    chk("uf_sticky", 128'(err_uf), 128'(2'b10));

    // Arbiter withholds the port for 20 cycles in CMD
    arb_grant = 1'b0;
    push_burst(0, BL, 1'b1, A_C0);
    ch_ready = 2'b01;
    wait_words(7*BL + 1);
    ch_ready = 2'b00;
    wait_words(8*BL);
    cmd_hi = 0;
    repeat (20) begin tick(); if (cmd_en) cmd_hi++; end
    chk("no_cmd_without_grant", 128'(cmd_hi), 128'd0);
    chk("cmds_before_grant", 128'(cmds_seen), 128'd7);
    arb_grant = 1'b1;
    wait_cmds(8);
    repeat (5) tick();
    chk("single_cmd_pulse", 128'(cmds_seen), 128'd8);

    // Reset after word 30 of a ch1 burst; the word presented during the
    // reset cycle is still popped, so 31 words are expected.
    push_burst(1, 31, 1'b0, 30'd0);
    ch_ready = 2'b10;
    wait_words(8*BL + 1);
    ch_ready = 2'b00;
    wait_words(8*BL + 30);
    mem_rst = 1'b1;
    tick();
    mem_rst = 1'b0;
    @(negedge clk);
    calib_done = 1'b0;
    chk_reset_vals();

    // No calibration: nothing may start even with channels ready
    ch_ready = 2'b11;
    repeat (100) tick();
    chk("nocal_busy", {127'd0, busy}, 128'd0);
    chk("nocal_words", 128'(words_seen), 128'(8*BL + 31));
    chk("nocal_cmds", 128'(cmds_seen), 128'd8);
    ch_ready = 2'b00;

    chk("words_left", 128'(wq.size()), 128'd0);
    chk("cmds_left", 128'(cq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
